// File: rtl/ifid_skid_reg_pkg.sv
// Shared types for the IF/ID boundary register: control state, entry layout
// and the reset/bubble constants.
package ifid_skid_reg_pkg;

    localparam int unsigned IFID_DATA_W = 32;

    // sll $0,$0,0 encodes as all zeros; used as the bubble instruction.
    localparam logic [IFID_DATA_W-1:0] IFID_NOP_WORD = 32'h0000_0000;
    localparam logic [IFID_DATA_W-1:0] IFID_PC_RST   = 32'h0000_0000;

    // Encoding doubles as the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } ifid_state_t;

    typedef struct packed {
        logic [IFID_DATA_W-1:0] pc4;
        logic [IFID_DATA_W-1:0] instr;
    } ifid_entry_t;

    function automatic logic [1:0] occ_of(ifid_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/ifid_skid_reg_entry.sv
// One IF/ID entry ({pc4, instr}) with load enable and synchronous clear.
// Reset and clear both return the entry to {PC_RST, NOP_WORD}.
module ifid_entry
    import ifid_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = IFID_DATA_W,
    parameter logic [DATA_W-1:0] PC_RST   = '0,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] instr_o
);

    logic [2*DATA_W-1:0] entry_q;
    logic [2*DATA_W-1:0] entry_d;

    // Clear wins over load so a flush always leaves a clean bubble.
    always_comb begin
        entry_d = {pc4_i, instr_i};
        if (clr_i) begin
            entry_d = {PC_RST, NOP_WORD};
        end
    end

    // Register only changes on clear or load; otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= {PC_RST, NOP_WORD};
        end else if (clr_i || en_i) begin
            entry_q <= entry_d;
        end
    end

    assign pc4_o   = entry_q[2*DATA_W-1:DATA_W];
    assign instr_o = entry_q[DATA_W-1:0];

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid must not depend on ready, and up_ready is a flop so decode's
// dn_ready never reaches fetch combinationally.
module ifid_skid_reg
    import ifid_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = IFID_DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD = IFID_NOP_WORD,
    parameter logic [DATA_W-1:0] PC_RST   = IFID_PC_RST
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_pc4,
    input  logic [DATA_W-1:0] up_instr,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_pc4,
    output logic [DATA_W-1:0] dn_instr,
    output logic [1:0]        occupancy,
    output ifid_state_t       state_dbg
);

    ifid_state_t state_q, state_d;
    logic        up_ready_q, up_ready_d;
    logic        accept, consume;
    logic        main_en, main_clr, skid_en, skid_clr, main_from_skid;
    logic [DATA_W-1:0] main_pc4, main_instr, skid_pc4, skid_instr;
    logic [DATA_W-1:0] main_pc4_d, main_instr_d;

    assign accept  = up_valid & up_ready_q;
    assign consume = dn_valid & dn_ready;

    // State and registered up_ready; reset leaves the block empty and ready.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= EMPTY;
            up_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            up_ready_q <= up_ready_d;
        end
    end

    // Next state: flush dominates, otherwise follow accept/consume.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL: begin
                    if (accept && !consume)      state_d = SKID;
                    else if (!accept && consume) state_d = EMPTY;
                end
                SKID:    if (consume) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
        up_ready_d = (state_d != SKID);
    end

    // Register enables: each entry loads only on its transition condition.
    always_comb begin
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = flush;
        skid_clr       = flush;
        if (!flush) begin
            case (state_q)
                EMPTY: main_en = accept;
                FULL: begin
                    main_en = accept & consume;
                    skid_en = accept & ~consume;
                end
                SKID: begin
                    main_en        = consume;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
        main_pc4_d   = main_from_skid ? skid_pc4   : up_pc4;
        main_instr_d = main_from_skid ? skid_instr : up_instr;
    end

    ifid_entry #(
        .DATA_W  (DATA_W),
        .PC_RST  (PC_RST),
        .NOP_WORD(NOP_WORD)
    ) u_main (
        .clk    (clk),
        .rst_n  (areset),
        .en_i   (main_en),
        .clr_i  (main_clr),
        .pc4_i  (main_pc4_d),
        .instr_i(main_instr_d),
        .pc4_o  (main_pc4),
        .instr_o(main_instr)
    );

    ifid_entry #(
        .DATA_W  (DATA_W),
        .PC_RST  (PC_RST),
        .NOP_WORD(NOP_WORD)
    ) u_skid (
        .clk    (clk),
        .rst_n  (areset),
        .en_i   (skid_en),
        .clr_i  (skid_clr),
        .pc4_i  (up_pc4),
        .instr_i(up_instr),
        .pc4_o  (skid_pc4),
        .instr_o(skid_instr)
    );

    assign up_ready  = up_ready_q;
    assign dn_valid  = (state_q != EMPTY);
    assign dn_pc4    = main_pc4;
    // Stale main contents are masked whenever nothing is presented.
    assign dn_instr  = dn_valid ? main_instr : NOP_WORD;
    assign occupancy = occ_of(state_q);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed scenarios plus a random phase, with a
// scoreboard queue tracking every accepted entry until decode consumes it.
module tb_ifid_skid_reg;
    import ifid_skid_reg_pkg::*;

    localparam int          W   = 32;
    localparam logic [W-1:0] NOP = 32'h0000_0000;
    localparam logic [W-1:0] PCR = 32'h0000_0000;

    logic         clk;
    logic         areset;
    logic         flush;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_pc4;
    logic [W-1:0] up_instr;
    logic         dn_valid;
    logic         dn_ready;
    logic [W-1:0] dn_pc4;
    logic [W-1:0] dn_instr;
    logic [1:0]   occupancy;
    ifid_state_t  state_dbg;

    int compared;
    int mismatched;
    logic [2*W-1:0] exp_q[$];

    ifid_skid_reg #(
        .DATA_W  (W),
        .NOP_WORD(NOP),
        .PC_RST  (PCR)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .flush    (flush),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_pc4   (up_pc4),
        .up_instr (up_instr),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_pc4   (dn_pc4),
        .dn_instr (dn_instr),
        .occupancy(occupancy),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Called at the falling edge: checks outputs against the queue model and
    // records what the coming rising edge will transfer.
    task automatic sb_sample();
        int n;
        logic [2*W-1:0] got;
        logic [2*W-1:0] exp;
        if (!areset) begin
            exp_q.delete();
            return;
        end
        n = exp_q.size();
        compared++;
        if (occupancy !== 2'(n)) begin
            mismatched++;
            $display("FAIL sb_occupancy: got %0d expected %0d @%0t", occupancy, n, $time);
        end
        compared++;
        if (dn_valid !== 1'(n != 0)) begin
            mismatched++;
            $display("FAIL sb_dn_valid: got %0b expected %0b @%0t", dn_valid, (n != 0), $time);
        end
        compared++;
        if (up_ready !== 1'(n < 2)) begin
            mismatched++;
            $display("FAIL sb_up_ready: got %0b expected %0b @%0t", up_ready, (n < 2), $time);
        end
        if (!dn_valid) begin
            compared++;
            if (dn_instr !== NOP) begin
                mismatched++;
                $display("FAIL sb_bubble_instr: got %h expected %h @%0t", dn_instr, NOP, $time);
            end
        end
        if (dn_valid && dn_ready) begin
            got = {dn_pc4, dn_instr};
            compared++;
            if (n == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected: got %h expected none @%0t", got, $time);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL sb_order: got %h expected %h @%0t", got, exp, $time);
                end
            end
        end
        if (flush) begin
            exp_q.delete();
        end else if (up_valid && n < 2) begin
            exp_q.push_back({up_pc4, up_instr});
        end
    endtask

    // One clock: sample at the falling edge, return 1 time unit after rising.
    task automatic cycle();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (4) begin
            up_valid = 1'($urandom_range(0, 1));
            up_pc4   = $urandom;
            up_instr = $urandom;
            dn_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        up_valid = 1'b1;
        up_pc4   = $urandom;
        up_instr = $urandom;
        #3 areset = 1'b0;
        exp_q.delete();
        for (int ph = 0; ph < 3; ph++) begin
            #1;
            compared++;
            if (dn_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_dn_valid[%0d]: got %0b expected 0", ph, dn_valid);
            end
            compared++;
            if (dn_instr !== NOP) begin
                mismatched++;
                $display("FAIL reset_dn_instr[%0d]: got %h expected %h", ph, dn_instr, NOP);
            end
            compared++;
            if (dn_pc4 !== PCR) begin
                mismatched++;
                $display("FAIL reset_dn_pc4[%0d]: got %h expected %h", ph, dn_pc4, PCR);
            end
            compared++;
            if (up_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_up_ready[%0d]: got %0b expected 1", ph, up_ready);
            end
            compared++;
            if (occupancy !== 2'd0) begin
                mismatched++;
                $display("FAIL reset_occupancy[%0d]: got %0d expected 0", ph, occupancy);
            end
            if (ph == 0) begin
                @(posedge clk);
                #1;
                areset   = 1'b1;
                up_valid = 1'b0;
                dn_ready = 1'b0;
            end else begin
                cycle();
                #(-0);
            end
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] ins [3];
        ins[0] = 32'h8C01_0004;
        ins[1] = 32'h0022_1820;
        ins[2] = 32'h1000_FFFE;
        dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_pc4   = 32'(4 * (i + 1));
            up_instr = ins[i];
            cycle();
            compared++;
            if (dn_valid !== 1'b1 || occupancy !== 2'd1) begin
                mismatched++;
                $display("FAIL stream_valid[%0d]: got v=%0b occ=%0d expected v=1 occ=1", i, dn_valid, occupancy);
            end
            compared++;
            if (dn_instr !== ins[i] || dn_pc4 !== 32'(4 * (i + 1))) begin
                mismatched++;
                $display("FAIL stream_data[%0d]: got %h/%h expected %h/%h", i, dn_pc4, dn_instr, 32'(4 * (i + 1)), ins[i]);
            end
        end
        up_valid = 1'b0;
        cycle();
        compared++;
        if (dn_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_drain: got dn_valid=%0b expected 0", dn_valid);
        end
    endtask

    task automatic test_back_pressure();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_pc4   = 32'd4;
        up_instr = 32'h8C01_0004;
        cycle();
        compared++;
        if (occupancy !== 2'd1 || dn_instr !== 32'h8C01_0004) begin
            mismatched++;
            $display("FAIL bp_first: got occ=%0d instr=%h expected 1/8c010004", occupancy, dn_instr);
        end
        up_pc4   = 32'd8;
        up_instr = 32'h0022_1820;
        cycle();
        compared++;
        if (occupancy !== 2'd2 || up_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_skid: got occ=%0d up_ready=%0b expected 2/0", occupancy, up_ready);
        end
        compared++;
        if (dn_pc4 !== 32'd4 || dn_instr !== 32'h8C01_0004) begin
            mismatched++;
            $display("FAIL bp_hold_a: got %h/%h expected 4/8c010004", dn_pc4, dn_instr);
        end
        // Garbage presented while up_ready=0 must not reach any register.
        up_pc4   = 'x;
        up_instr = 'x;
        cycle();
        compared++;
        if (occupancy !== 2'd2 || dn_pc4 !== 32'd4 || dn_instr !== 32'h8C01_0004) begin
            mismatched++;
            $display("FAIL bp_x_hold: got occ=%0d %h/%h expected 2 4/8c010004", occupancy, dn_pc4, dn_instr);
        end
        up_valid = 1'b0;
        up_pc4   = '0;
        up_instr = '0;
        dn_ready = 1'b1;
        cycle();
        compared++;
        if (dn_pc4 !== 32'd8 || dn_instr !== 32'h0022_1820 || up_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release_b: got %h/%h rdy=%0b expected 8/00221820 rdy=1", dn_pc4, dn_instr, up_ready);
        end
        cycle();
        compared++;
        if (dn_valid !== 1'b0 || dn_instr !== NOP || occupancy !== 2'd0) begin
            mismatched++;
            $display("FAIL bp_empty: got v=%0b instr=%h occ=%0d expected 0/%h/0", dn_valid, dn_instr, occupancy, NOP);
        end
        dn_ready = 1'b0;
    endtask

    task automatic test_flush();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_pc4   = 32'd4;
        up_instr = 32'h8C01_0004;
        cycle();
        up_pc4   = 32'd8;
        up_instr = 32'h0022_1820;
        cycle();
        flush    = 1'b1;
        up_pc4   = 32'd12;
        up_instr = 32'h1000_FFFE;
        cycle();
        flush    = 1'b0;
        up_valid = 1'b0;
        compared++;
        if (dn_valid !== 1'b0 || dn_instr !== NOP || dn_pc4 !== PCR) begin
            mismatched++;
            $display("FAIL flush_skid_out: got v=%0b %h/%h expected 0 %h/%h", dn_valid, dn_pc4, dn_instr, PCR, NOP);
        end
        compared++;
        if (occupancy !== 2'd0 || up_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_skid_state: got occ=%0d rdy=%0b expected 0/1", occupancy, up_ready);
        end
        dn_ready = 1'b1;
        repeat (3) begin
            cycle();
            compared++;
            if (dn_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_no_c: got dn_valid=%0b expected 0", dn_valid);
            end
        end
        // Flush in FULL: the consume still happens, the new accept is dropped.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_pc4   = 32'd16;
        up_instr = 32'h2402_0005;
        cycle();
        dn_ready = 1'b1;
        flush    = 1'b1;
        up_pc4   = 32'd20;
        up_instr = 32'h2403_0006;
        cycle();
        flush    = 1'b0;
        up_valid = 1'b0;
        compared++;
        if (dn_valid !== 1'b0 || occupancy !== 2'd0) begin
            mismatched++;
            $display("FAIL flush_full_drop: got v=%0b occ=%0d expected 0/0", dn_valid, occupancy);
        end
        cycle();
        dn_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pcs [10];
        logic [W-1:0] ins [10];
        dn_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pcs[i]   = 32'h0000_0100 + 32'(4 * i);
            ins[i]   = $urandom;
            up_valid = 1'b1;
            up_pc4   = pcs[i];
            up_instr = ins[i];
            cycle();
            compared++;
            if (occupancy !== 2'd1) begin
                mismatched++;
                $display("FAIL b2b_occ[%0d]: got %0d expected 1", i, occupancy);
            end
            compared++;
            if (dn_pc4 !== pcs[i] || dn_instr !== ins[i]) begin
                mismatched++;
                $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, dn_pc4, dn_instr, pcs[i], ins[i]);
            end
        end
        up_valid = 1'b0;
        cycle();
        dn_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            up_valid = 1'($urandom_range(0, 1));
            up_pc4   = $urandom;
            up_instr = $urandom;
            dn_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush    = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b1;
        repeat (3) cycle();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL random_drain: got %0d left expected 0", exp_q.size());
        end
        dn_ready = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        areset     = 1'b0;
        flush      = 1'b0;
        up_valid   = 1'b0;
        up_pc4     = '0;
        up_instr   = '0;
        dn_ready   = 1'b0;
        #12 areset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
